// File: rtl/regfile_sb_if.sv
// Port bundle for the Y86-64 register file: decode reads, write-back commits, issue tracking.
// The core side uses the master modport and the register file uses the slave modport.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 64
);
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic              wb_valid;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic              iss_valid;
    logic [3:0]        iss_dstE;
    logic [3:0]        iss_dstM;
    logic              busyA;
    logic              busyB;
    logic              sb_err;

    modport master (
        output srcA, srcB, wb_valid, dstE, dstM, valE, valM, iss_valid, iss_dstE, iss_dstM,
        input  valA, valB, busyA, busyB, sb_err
    );

    modport slave (
        input  srcA, srcB, wb_valid, dstE, dstM, valE, valM, iss_valid, iss_dstE, iss_dstM,
        output valA, valB, busyA, busyB, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Y86-64 register file with two combinational read ports and per-register pending-write counters.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and to hide retiring writes from busy.
module regfile_sb #(
    parameter int unsigned       DATA_W       = 64,
    parameter int unsigned       NREG         = 15,
    parameter logic [DATA_W-1:0] STACK_INIT   = DATA_W'(64'h200),
    parameter int unsigned       MAX_INFLIGHT = 3
) (
    input logic          clk,
    input logic          rst,
    regfile_sb_if.slave  bus
);

    localparam int unsigned CntW = (MAX_INFLIGHT > 0) ? $clog2(MAX_INFLIGHT + 1) : 1;
    typedef logic [CntW-1:0] cnt_t;

    logic [DATA_W-1:0] file_q   [NREG];
    logic [DATA_W-1:0] file_d   [NREG];
    cnt_t              cnt_q    [NREG];
    cnt_t              cnt_d    [NREG];
    logic [1:0]        inc      [NREG];
    logic [1:0]        dec      [NREG];
    logic [DATA_W-1:0] rd_data  [NREG];
    logic              busy_reg [NREG];
    logic              sb_err_q;
    logic              sb_err_d;

    // Write-back: valM is applied after valE so it wins when both target one register.
    always_comb begin : write_next
        for (int i = 0; i < int'(NREG); i++) begin
            file_d[i] = file_q[i];
            if (bus.wb_valid && (bus.dstE == 4'(i))) begin
                file_d[i] = bus.valE;
            end
            if (bus.wb_valid && (bus.dstM == 4'(i))) begin
                file_d[i] = bus.valM;
            end
        end
    end

    // Counter update is evaluated as a signed int so over/underflow is detected before clamping.
    always_comb begin : sb_next
        int sum;
        sum      = 0;
        sb_err_d = sb_err_q;
        for (int i = 0; i < int'(NREG); i++) begin
            inc[i] = {1'b0, bus.iss_valid && (bus.iss_dstE == 4'(i))}
                   + {1'b0, bus.iss_valid && (bus.iss_dstM == 4'(i))};
            dec[i] = {1'b0, bus.wb_valid && (bus.dstE == 4'(i))}
                   + {1'b0, bus.wb_valid && (bus.dstM == 4'(i))};
            sum      = int'(cnt_q[i]) + int'(inc[i]) - int'(dec[i]);
            cnt_d[i] = CntW'(sum);
            if (sum > int'(MAX_INFLIGHT)) begin
                cnt_d[i] = CntW'(MAX_INFLIGHT);
                sb_err_d = 1'b1;
            end else if (sum < 0) begin
                cnt_d[i] = '0;
                sb_err_d = 1'b1;
            end
        end
    end

    always_comb begin : per_reg_view
        for (int i = 0; i < int'(NREG); i++) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.wb_valid && (bus.dstM == 4'(i))) begin
                rd_data[i] = bus.valM;
            end else if (bus.wb_valid && (bus.dstE == 4'(i))) begin
                rd_data[i] = bus.valE;
            end else begin
                rd_data[i] = file_q[i];
            end
            busy_reg[i] = 32'(cnt_q[i]) > 32'(dec[i]);
`else
            rd_data[i]  = file_q[i];
            busy_reg[i] = (cnt_q[i] != '0);
`endif
        end
    end

    // Index 4'hF and anything at or beyond NREG never match, so those ports read 0 / not busy.
    always_comb begin : read_ports
        bus.valA  = '0;
        bus.valB  = '0;
        bus.busyA = 1'b0;
        bus.busyB = 1'b0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (bus.srcA == 4'(i)) begin
                bus.valA  = rd_data[i];
                bus.busyA = busy_reg[i];
            end
            if (bus.srcB == 4'(i)) begin
                bus.valB  = rd_data[i];
                bus.busyB = busy_reg[i];
            end
        end
    end

    assign bus.sb_err = sb_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                file_q[i] <= (i == 4) ? STACK_INIT : '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                file_q[i] <= file_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, write priority, scoreboard counting, clamping and reset.
// Expectations adapt to whether REGFILE_BYPASS_EN is defined.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_sb_if #(.DATA_W(64)) bus ();

    regfile_sb #(
        .DATA_W       (64),
        .NREG         (15),
        .STACK_INIT   (64'h200),
        .MAX_INFLIGHT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid  = 1'b0;
        bus.dstE      = 4'hF;
        bus.dstM      = 4'hF;
        bus.valE      = '0;
        bus.valM      = '0;
        bus.iss_valid = 1'b0;
        bus.iss_dstE  = 4'hF;
        bus.iss_dstM  = 4'hF;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.srcA = 4'hF;
        bus.srcB = 4'hF;
        idle();
        #1;

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.srcA = 4'd4;
        bus.srcB = 4'd0;
        #1;
        chk("rst_valA_rsp", bus.valA, 64'h200);
        chk("rst_valB_r0", bus.valB, 64'h0);
        chk("rst_busyA", {63'b0, bus.busyA}, 64'h0);
        chk("rst_busyB", {63'b0, bus.busyB}, 64'h0);
        chk("rst_sb_err", {63'b0, bus.sb_err}, 64'h0);
        bus.srcB = 4'hF;
        #1;
        chk("none_valB", bus.valB, 64'h0);

        // dstE==dstM: valM wins; retiring without issue underflows
        bus.wb_valid = 1'b1;
        bus.dstE = 4'd3; bus.valE = 64'd5;
        bus.dstM = 4'd3; bus.valM = 64'd9;
        bus.srcA = 4'd3;
        #1;
        chk("same_cycle_valA", bus.valA, BYP ? 64'd9 : 64'd0);
        tick();
        idle();
        #1;
        chk("popq_valA", bus.valA, 64'd9);
        chk("underflow_err", {63'b0, bus.sb_err}, 64'h1);
        chk("underflow_busy", {63'b0, bus.busyA}, 64'h0);

        // wb_valid=0 writes nothing
        bus.dstE = 4'd6; bus.valE = 64'd7;
        bus.srcA = 4'd6;
        tick();
        idle();
        #1;
        chk("nowb_valA", bus.valA, 64'd0);
        chk("nowb_busy", {63'b0, bus.busyA}, 64'h0);
        chk("err_sticky", {63'b0, bus.sb_err}, 64'h1);

        // Reset clears file and error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.srcA = 4'd3;
        bus.srcB = 4'd4;
        #1;
        chk("rst2_valA", bus.valA, 64'd0);
        chk("rst2_valB", bus.valB, 64'h200);
        chk("rst2_err", {63'b0, bus.sb_err}, 64'h0);

        // Issue then retire on register 2
        bus.iss_valid = 1'b1; bus.iss_dstE = 4'd2;
        bus.srcA = 4'd2;
        tick();
        idle();
        #1;
        chk("issue_busyA", {63'b0, bus.busyA}, 64'h1);
        bus.wb_valid = 1'b1; bus.dstE = 4'd2; bus.valE = 64'h22;
        #1;
        chk("retire_busyA", {63'b0, bus.busyA}, BYP ? 64'h0 : 64'h1);
        chk("retire_valA", bus.valA, BYP ? 64'h22 : 64'h0);
        tick();
        idle();
        #1;
        chk("after_busyA", {63'b0, bus.busyA}, 64'h0);
        chk("after_valA", bus.valA, 64'h22);
        chk("after_err", {63'b0, bus.sb_err}, 64'h0);

        // Same-cycle issue and retire nets out
        bus.iss_valid = 1'b1; bus.iss_dstE = 4'd2;
        tick();
        bus.wb_valid = 1'b1; bus.dstE = 4'd2; bus.valE = 64'h33;
        tick();
        idle();
        #1;
        chk("net_busyA", {63'b0, bus.busyA}, 64'h1);
        chk("net_err", {63'b0, bus.sb_err}, 64'h0);
        bus.wb_valid = 1'b1; bus.dstE = 4'd2; bus.valE = 64'h44;
        tick();
        idle();
        #1;
        chk("net_drain_busy", {63'b0, bus.busyA}, 64'h0);
        chk("net_drain_val", bus.valA, 64'h44);

        // Double issue (dstE==dstM) counts two
        bus.srcB = 4'd7;
        bus.iss_valid = 1'b1; bus.iss_dstE = 4'd7; bus.iss_dstM = 4'd7;
        tick();
        idle();
        bus.wb_valid = 1'b1; bus.dstE = 4'd7; bus.valE = 64'h77;
        tick();
        idle();
        #1;
        chk("dbl_busyB_1left", {63'b0, bus.busyB}, 64'h1);
        bus.wb_valid = 1'b1; bus.dstE = 4'd7; bus.valE = 64'h78;
        tick();
        idle();
        #1;
        chk("dbl_busyB_0left", {63'b0, bus.busyB}, 64'h0);
        chk("dbl_err", {63'b0, bus.sb_err}, 64'h0);

        // Overflow: four issues to reg 1 clamp at 3
        bus.srcB = 4'd1;
        for (int k = 0; k < 3; k++) begin
            bus.iss_valid = 1'b1; bus.iss_dstE = 4'd1;
            tick();
        end
        idle();
        #1;
        chk("ovf_3_err", {63'b0, bus.sb_err}, 64'h0);
        bus.iss_valid = 1'b1; bus.iss_dstE = 4'd1;
        tick();
        idle();
        #1;
        chk("ovf_4_err", {63'b0, bus.sb_err}, 64'h1);
        chk("ovf_busyB", {63'b0, bus.busyB}, 64'h1);
        for (int k = 0; k < 2; k++) begin
            bus.wb_valid = 1'b1; bus.dstE = 4'd1; bus.valE = 64'(k + 1);
            tick();
        end
        idle();
        #1;
        chk("ovf_2ret_busy", {63'b0, bus.busyB}, 64'h1);
        bus.wb_valid = 1'b1; bus.dstE = 4'd1; bus.valE = 64'h3;
        tick();
        idle();
        #1;
        chk("ovf_clamped_busy", {63'b0, bus.busyB}, 64'h0);
        chk("ovf_err_sticky", {63'b0, bus.sb_err}, 64'h1);

        // Reset overrides pending write and in-flight count on reg 2
        bus.srcA = 4'd2;
        bus.iss_valid = 1'b1; bus.iss_dstE = 4'd2; bus.iss_dstM = 4'd2;
        tick();
        idle();
        #1;
        chk("pre_rst_busyA", {63'b0, bus.busyA}, 64'h1);
        rst = 1'b1;
        bus.wb_valid = 1'b1; bus.dstE = 4'd2; bus.valE = 64'h55;
        bus.iss_valid = 1'b1; bus.iss_dstE = 4'd2;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst3_valA", bus.valA, 64'h0);
        chk("rst3_busyA", {63'b0, bus.busyA}, 64'h0);
        chk("rst3_err", {63'b0, bus.sb_err}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
